// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC capture path: frame sequencer states,
// the conversion word width and a small constant helper.
package adc_pkg;

  localparam int ADC_DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } adc_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ADCregs.sv
// Serial-in, parallel-out shift register fed by the ADC data line.
// The first bit shifted in ends up in q[DATA_W-1].
module ADCregs
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[DATA_W-2:0], in};
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Frame sequencer around ADCregs: chip select, settle delay, DATA_W shift
// enables, then a single-word output register with valid/ready and overrun.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W        = ADC_DATA_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              adc_cs_n,
  output logic              shift_en,
  input  logic [DATA_W-1:0] shreg_q,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int CNT_W = $clog2(max_int(DATA_W, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(DATA_W - 1);
  // With no settle time the SETTLE state is never entered, so its limit is moot.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  adc_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             capture, accept_word, drop_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    adc_cs_n   = 1'b1;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_next   = '0;
          state_next = (SETTLE_CYCLES > 0) ? SETTLE : SHIFT;
        end
      end
      SETTLE: begin
        adc_cs_n = 1'b0;
        if (cnt == SETTLE_LAST) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        adc_cs_n = 1'b0;
        shift_en = 1'b1;
        if (cnt == SHIFT_LAST) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // A word held unconsumed at capture time keeps priority; the new one is lost.
  assign capture     = (state == CAPTURE);
  assign accept_word = capture && (!valid || ready);
  assign drop_word   = capture && valid && !ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept_word) begin
        data  <= shreg_q;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop_word) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl + ADCregs with a serial ADC model; a second
// instance is built with no settle time.
module tb_adc_capture_ctrl;
  import adc_pkg::*;

  localparam int W = ADC_DATA_W;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, ready, clr_overrun, serial_in;
  logic         adc_cs_n, shift_en, valid, busy, overrun;
  logic [W-1:0] shreg_q, data, adc_word;

  logic         start0, ready0, clr0, serial_in0;
  logic         adc_cs_n0, shift_en0, valid0, busy0, overrun0;
  logic [W-1:0] shreg_q0, data0, adc_word0;

  ADCregs #(.DATA_W(W)) u_sreg (
    .clk(clk), .reset_n(reset_n), .en(shift_en), .in(serial_in), .q(shreg_q)
  );

  adc_capture_ctrl #(.DATA_W(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .adc_cs_n(adc_cs_n),
    .shift_en(shift_en), .shreg_q(shreg_q), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  ADCregs #(.DATA_W(W)) u_sreg0 (
    .clk(clk), .reset_n(reset_n), .en(shift_en0), .in(serial_in0), .q(shreg_q0)
  );

  adc_capture_ctrl #(.DATA_W(W), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .adc_cs_n(adc_cs_n0),
    .shift_en(shift_en0), .shreg_q(shreg_q0), .data(data0), .valid(valid0),
    .ready(ready0), .busy(busy0), .overrun(overrun0), .clr_overrun(clr0)
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model: a frame is just "started at cycle m_t"; outputs follow
  // from the elapsed cycle count, the output stage from the handshake rules.
  int           cyc = 0;
  int           m_t = 0;
  logic         m_active = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic [W-1:0] m_data = '0;
  int           idx = 0;
  int           idx0 = 0;

  typedef struct {
    logic        reset_n;
    logic        start;
    logic        ready;
    logic        clr;
    int          reps;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [14:0] pack(input logic cs, input logic sh, input logic b,
                                       input logic v, input logic o, input logic [W-1:0] d);
    return {cs, sh, b, v, o, d};
  endfunction

  function automatic vec_t mkVec(input logic rn, input logic st, input logic rdy, input logic clr,
                                 input int reps, input logic [14:0] exp, input string name);
    vec_t v;
    v.reset_n = rn; v.start = st; v.ready = rdy; v.clr = clr;
    v.reps = reps; v.exp = exp; v.name = name;
    return v;
  endfunction

  function automatic logic [14:0] modelExp();
    int   d  = cyc - m_t;
    logic cs = !(m_active && d <= S + W);
    logic sh = m_active && d >= S + 1 && d <= S + W;
    return {cs, sh, m_active, m_valid, m_ovr, m_data};
  endfunction

  task automatic modelUpdate();
    logic capture, drop;
    if (!reset_n) begin
      m_active = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    end else begin
      capture = m_active && (cyc - m_t == S + W + 1);
      drop    = capture && m_valid && !ready;
      if (capture && !drop) begin
        m_data = adc_word; m_valid = 1'b1;
      end else if (!capture && m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      if (capture) m_active = 1'b0;
      else if (!m_active && start) begin
        m_active = 1'b1; m_t = cyc;
      end
    end
    cyc++;
  endtask

  task automatic adcDrive();
    int b;
    if (shift_en) begin
      b = W - 1 - idx;
      serial_in = (idx < W) ? adc_word[b] : 1'b0;
      idx++;
    end else begin
      idx = 0; serial_in = 1'b0;
    end
    if (shift_en0) begin
      b = W - 1 - idx0;
      serial_in0 = (idx0 < W) ? adc_word0[b] : 1'b0;
      idx0++;
    end else begin
      idx0 = 0; serial_in0 = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    adcDrive();
  endtask

  task automatic applyStimulus(input logic rn, input logic st, input logic rdy, input logic clr);
    reset_n = rn; start = st; ready = rdy; clr_overrun = clr;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] exp_v);
    logic [14:0] act;
    act = {adc_cs_n, shift_en, busy, valid, overrun, data};
    n_vectors++;
    if (act !== exp_v) begin
      n_miscompares++;
      $display("[TB] FAIL %s cyc=%0d got cs_n=%b sh=%b busy=%b valid=%b ovr=%b data=%h want cs_n=%b sh=%b busy=%b valid=%b ovr=%b data=%h",
               name, cyc, act[14], act[13], act[12], act[11], act[10], act[9:0],
               exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10], exp_v[9:0]);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp_v);
    n_vectors++;
    if (act != exp_v) begin
      n_miscompares++;
      $display("[TB] FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic runCycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      checkOutput(name, modelExp());
      step();
    end
  endtask

  initial begin
    int rises, shifts;
    logic prev_busy;
    logic rn, st, rdy, clr;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    start0 = 1'b0; ready0 = 1'b1; clr0 = 1'b0;
    adc_word = '0; adc_word0 = '0; serial_in = 1'b0; serial_in0 = 1'b0;
    @(negedge clk);
    step();
    step();

    // Default conversion of 10'b1011001110, cycle by cycle from the start pulse.
    tbl[0] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1,  pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000), "reset_idle");
    tbl[1] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 1,  pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000), "start_cycle");
    tbl[2] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 2,  pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000), "settle");
    tbl[3] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 10, pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000), "shift");
    tbl[4] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1,  pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000), "capture");
    tbl[5] = mkVec(1'b1, 1'b0, 1'b1, 1'b0, 1,  pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h2CE), "valid_rise");
    tbl[6] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 2,  pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h2CE), "consumed");

    adc_word = 10'b1011001110;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        applyStimulus(tbl[r].reset_n, tbl[r].start, tbl[r].ready, tbl[r].clr);
        checkOutput(tbl[r].name, tbl[r].exp);
        step();
      end
    end

    // Backpressure: second word dropped, first retained, overrun sticky then cleared.
    adc_word = 10'h155;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); runCycles(1, "bp_start1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); runCycles(13, "bp_frame1");
    checkValue("bp_data1", int'(data), 'h155);
    adc_word = 10'h2AA;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); runCycles(1, "bp_start2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); runCycles(13, "bp_frame2");
    checkValue("bp_data_held", int'(data), 'h155);
    checkValue("bp_overrun_set", int'(overrun), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1); runCycles(1, "bp_clr");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("bp_overrun_clr", int'(overrun), 0);
    checkValue("bp_data_after_clr", int'(data), 'h155);

    // Consume the held word in the very cycle the next one is captured.
    adc_word = 10'h3FF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); runCycles(1, "acc_start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); runCycles(12, "acc_frame");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); runCycles(1, "acc_capture");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("acc_data", int'(data), 'h3FF);
    checkValue("acc_valid", int'(valid), 1);
    checkValue("acc_overrun", int'(overrun), 0);

    // Start held high: frames every S+W+2 cycles, never restarted while busy.
    adc_word = 10'h1A5;
    rises = 0; shifts = 0; prev_busy = busy;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      if (busy && !prev_busy) rises++;
      if (shift_en) shifts++;
      prev_busy = busy;
      checkOutput("hold_start", modelExp());
      step();
    end
    checkValue("hold_frames", rises, 2);
    checkValue("hold_shift_cycles", shifts, 2 * W);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); runCycles(2, "hold_tail");

    // Reset during the 5th shift cycle, then a clean conversion.
    adc_word = 10'h0F3;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); runCycles(1, "rst_start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); runCycles(6, "rst_frame");
    checkValue("rst_in_shift", int'(shift_en), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); runCycles(1, "rst_assert");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("rst_idle", int'({adc_cs_n, shift_en, valid, busy}), 'b1000);
    adc_word = 10'h2B7;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); runCycles(1, "rst_restart");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); runCycles(13, "rst_frame2");
    checkValue("rst_new_word", int'({valid, data}), int'({1'b1, 10'h2B7}));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); runCycles(1, "rst_drain");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Zero settle instance: shift t+1..t+10, capture t+11, valid at t+12 only.
    adc_word0 = 10'h1C9;
    for (int k = 0; k < 14; k++) begin
      start0 = (k == 0);
      checkValue($sformatf("s0_k%0d", k), int'({adc_cs_n0, shift_en0, busy0, valid0, overrun0}),
                 int'({!(k >= 1 && k <= 10), (k >= 1 && k <= 10), (k >= 1 && k <= 11), (k == 12), 1'b0}));
      if (k == 12) checkValue("s0_data", int'(data0), 'h1C9);
      step();
    end
    start0 = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      if (!m_active) adc_word = W'($urandom);
      applyStimulus(rn, st, rdy, clr);
      checkOutput("random", modelExp());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Frame sequencer and output stage for the serial ADC path. Sits around the 10-bit serial-in shift register (ADCregs).
- On a start request, drives ADC chip-select and waits a settle time. Then asserts the shift register enable for exactly DATA_W cycles.
- Captures the assembled parallel word and presents it downstream on a valid/ready handshake, with overrun detection.

Parameters:
- DATA_W, 10, conversion word width; must equal the shift register length.
- SETTLE_CYCLES, 2, cycles between chip-select assertion and the first shift; 0 is legal.
- CNT_W, $clog2(max(DATA_W,SETTLE_CYCLES)+1), internal counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- adc_cs_n  out  1  ADC chip select, active low.
- shift_en  out  1  drives enable of the shift register.
- shreg_q  in  DATA_W  parallel output of the shift register.
- data  out  DATA_W  captured conversion word.
- valid  out  1  data holds an unconsumed word.
- ready  in  1  downstream accepts data when valid&ready.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky; a completed word was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, adc_cs_n=1, shift_en=0.
  - data=0, valid=0, overrun=0, counter=0.
  - Applies from any state; an in-progress frame is abandoned with no capture.
- FSM states:
  - IDLE: adc_cs_n=1, shift_en=0.
    - start=1 with SETTLE_CYCLES>0 -> SETTLE, counter=0.
    - start=1 with SETTLE_CYCLES=0 -> SHIFT directly.
  - SETTLE: adc_cs_n=0, shift_en=0. Counter increments. After SETTLE_CYCLES cycles in SETTLE -> SHIFT, counter=0.
  - SHIFT: adc_cs_n=0, shift_en=1. Counter increments. After exactly DATA_W cycles -> CAPTURE.
  - CAPTURE: adc_cs_n=1, shift_en=0. One cycle. shreg_q is complete here and is registered per the capture rule. Next state is always IDLE.
- Timing (start sampled high in cycle t):
  - SETTLE in cycles t+1..t+S.
  - shift_en=1 in cycles t+S+1..t+S+DATA_W.
  - CAPTURE in cycle t+S+DATA_W+1.
  - valid first high in cycle t+S+DATA_W+2.
  - With defaults, shift_en is high in cycles t+3..t+12 and valid rises at t+14.
- Start handling: start is ignored when busy=1, including in the CAPTURE cycle. Back-to-back frames need start high in the cycle after CAPTURE, giving a minimum frame period of S+DATA_W+2 cycles.
- Capture rule (CAPTURE cycle):
  - If valid=0, or valid=1 and ready=1: data<=shreg_q, valid<=1.
  - Otherwise (valid=1, ready=0): data is held, the new word is dropped, overrun<=1.
- Handshake:
  - valid&ready outside a CAPTURE cycle -> valid=0 next cycle.
  - data is stable while valid=1 and ready=0.
  - ready is ignored when valid=0.
- Overrun:
  - Sticky until clr_overrun=1 or reset.
  - If clr_overrun and a drop occur in the same cycle, set wins (overrun=1).
- Width rules:
  - Bit order passes through unchanged: data[DATA_W-1] is the first serial bit shifted.
  - Counters compare against DATA_W-1 and SETTLE_CYCLES-1; no wrap-around.
- Output timing: adc_cs_n, shift_en and busy are state-decoded, glitch-free and registered-state based. No combinational path from start or ready to any output.

Decomposition:
- Package adc_pkg: state enum (IDLE, SETTLE, SHIFT, CAPTURE) and ADC_DATA_W=10 constant, shared with the shift register wrapper and the bench.
- No sub-module: counter and FSM stay inline.
- Bench instantiates adc_capture_ctrl plus ADCregs, with a serial ADC model driving ADCregs.in on the cycles where shift_en=1.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, start=0 -> adc_cs_n=1, shift_en=0, valid=0, data=0, busy=0.
- Single conversion with defaults: start pulse at t, ADC model shifts 10'b1011001110 MSB-first -> shift_en high for exactly t+3..t+12, valid rises at t+14, data=10'h2CE; hold ready=1 at t+14 -> valid=0 at t+15.
- Backpressure overrun: ready=0, two conversions (0x155 then 0x2AA) -> data stays 0x155 and overrun=1 after the second CAPTURE; clr_overrun pulse -> overrun=0, data still 0x155.
- Accept and capture in the same cycle: valid=1 with ready=1 in the CAPTURE cycle of word 0x3FF -> data=0x3FF, valid stays 1, overrun=0.
- Start ignored while busy: start held high for 20 cycles -> exactly one frame per S+DATA_W+2 cycles, no frame restart mid-SHIFT.
- Reset mid-SHIFT: reset_n=0 in the 5th shift cycle -> next cycle IDLE, adc_cs_n=1, shift_en=0, valid=0; a new start gives a correct full 10-bit word.
- SETTLE_CYCLES=0 build: start at t -> shift_en high for t+1..t+10, valid rises at t+12.
